// File: rtl/main_memory.sv
// Line-organised main memory with a fixed access latency: word writes, full-line reads,
// one request in flight, completion signalled by a single-cycle mem_done pulse.
module main_memory #(
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned LATENCY    = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [31:0]                  mem_addr,
   input  logic [WORD_W-1:0]            mem_wdata,
   output logic [WORD_W*LINE_WORDS-1:0] mem_rdata,
   output logic                         mem_ready,
   output logic                         mem_done
);

   localparam int unsigned WordIdxW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int unsigned LineIdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned AddrUseW = WordIdxW + LineIdxW;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e                                 state_q, state_d;
   logic [3:0]                             cnt_q, cnt_d;
   logic [WordIdxW-1:0]                    word_q, word_d;
   logic [LineIdxW-1:0]                    line_q, line_d;
   logic [WORD_W-1:0]                      wdata_q, wdata_d;
   logic                                   is_read_q, is_read_d;
   logic                                   ready_q, ready_d;
   logic                                   done_q, done_d;
   logic [WORD_W*LINE_WORDS-1:0]           rdata_q, rdata_d;

   logic [LINE_WORDS-1:0][WORD_W-1:0]      mem_q [DEPTH];

   // Commit-side operands: taken straight from the inputs only when LATENCY=1
   // commits on the accepting edge, otherwise from the latched request.
   logic                                   commit;
   logic                                   c_read;
   logic [WordIdxW-1:0]                    c_word;
   logic [LineIdxW-1:0]                    c_line;
   logic [WORD_W-1:0]                      c_wdata;

   logic                                   unused_addr;
   assign unused_addr = ^mem_addr[31:AddrUseW];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      line_d    = line_q;
      wdata_d   = wdata_q;
      is_read_d = is_read_q;
      commit    = 1'b0;
      c_read    = is_read_q;
      c_word    = word_q;
      c_line    = line_q;
      c_wdata   = wdata_q;
      case (state_q)
         StIdle: begin
            if (ready_q && (mem_read || mem_write)) begin
               word_d    = mem_addr[WordIdxW-1:0];
               line_d    = mem_addr[WordIdxW +: LineIdxW];
               wdata_d   = mem_wdata;
               is_read_d = mem_read;
               cnt_d     = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d = StDone;
                  commit  = 1'b1;
                  c_read  = mem_read;
                  c_word  = mem_addr[WordIdxW-1:0];
                  c_line  = mem_addr[WordIdxW +: LineIdxW];
                  c_wdata = mem_wdata;
               end else begin
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            if (cnt_q == 4'd0) begin
               state_d = StDone;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      done_d  = commit;
      ready_d = (state_d == StIdle);
      rdata_d = (commit && c_read) ? mem_q[c_line] : rdata_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         word_q    <= '0;
         line_q    <= '0;
         wdata_q   <= '0;
         is_read_q <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         line_q    <= line_d;
         wdata_q   <= wdata_d;
         is_read_q <= is_read_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!reset && commit && !c_read) begin
         mem_q[c_line][c_word] <= c_wdata;
      end
   end

   assign mem_rdata = rdata_q;
   assign mem_ready = ready_q;
   assign mem_done  = done_q;

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: each accepted request queues its expected outcome,
// which is popped and checked when mem_done pulses.
module tb_main_memory;

   localparam int unsigned Lat = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic         mem_read, mem_write;
   logic [31:0]  mem_addr, mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready, mem_done;

   main_memory #(
      .WORD_W(32), .LINE_WORDS(4), .DEPTH(64), .LATENCY(Lat)
   ) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .mem_done(mem_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           is_read;
      logic [127:0] exp;
      logic [127:0] mask;
      int           acc;
   } sb_t;

   sb_t          sb[$];
   sb_t          mon_e;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           done_cnt = 0;
   logic [31:0]  model [64][4];
   bit           model_v [64][4];
   logic [127:0] last_exp = '0;
   logic [127:0] last_mask = '1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && mem_done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            check_eq("spurious_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check_eq("latency", 128'(cyc - mon_e.acc), 128'(Lat));
            check_eq("ready_low_in_done", {127'b0, mem_ready}, 128'd0);
            check_eq(mon_e.is_read ? "read_line" : "write_keeps_rdata",
                     mem_rdata & mon_e.mask, mon_e.exp & mon_e.mask);
         end
      end
   end

   // Waits for mem_ready, drives one request for one accepting edge.
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input bit push);
      int   n = 0;
      int   ln, wi;
      sb_t  e;
      @(negedge clk);
      while (!mem_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!mem_ready) begin
         check_eq("ready_timeout", 0, 1);
         return;
      end
      mem_read  = rd;
      mem_write = wr;
      mem_addr  = addr;
      mem_wdata = wd;
      ln = int'(addr[7:2]);
      wi = int'(addr[1:0]);
      if (push) begin
         e.acc = cyc + 1;
         e.is_read = rd;
         if (rd) begin
            for (int k = 0; k < 4; k++) begin
               e.exp[32*k +: 32]  = model_v[ln][k] ? model[ln][k] : 32'h0;
               e.mask[32*k +: 32] = model_v[ln][k] ? 32'hFFFF_FFFF : 32'h0;
            end
            last_exp  = e.exp;
            last_mask = e.mask;
         end else begin
            e.exp  = last_exp;
            e.mask = last_mask;
            model[ln][wi]   = wd;
            model_v[ln][wi] = 1'b1;
         end
         sb.push_back(e);
      end
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !mem_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) check_eq("drain_timeout", 128'(sb.size()), 0);
   endtask

   initial begin
      int d0;
      logic [31:0] ra, rv;
      for (int l = 0; l < 64; l++)
         for (int k = 0; k < 4; k++) model_v[l][k] = 1'b0;
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_ready", {127'b0, mem_ready}, 0);
      check_eq("reset_done", {127'b0, mem_done}, 0);
      check_eq("reset_rdata", mem_rdata, 0);
      reset = 1'b0;
      check_eq("ready_before_edge", {127'b0, mem_ready}, 0);
      @(negedge clk);
      check_eq("ready_after_reset", {127'b0, mem_ready}, 1);

      // Write then read.
      do_req(1'b0, 1'b1, 32'h05, 32'hDEAD_BEEF, 1'b1);
      do_req(1'b1, 1'b0, 32'h04, 32'h0, 1'b1);
      drain();
      check_eq("wr_rd_word1", {96'b0, mem_rdata[63:32]}, 128'hDEAD_BEEF);

      // Full line.
      for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 32'h10 + i, 32'(i + 1), 1'b1);
      do_req(1'b1, 1'b0, 32'h12, 32'h0, 1'b1);
      drain();
      check_eq("full_line", mem_rdata, 128'h00000004_00000003_00000002_00000001);

      // Aliasing through ignored upper address bits.
      do_req(1'b0, 1'b1, 32'h104, 32'hA5A5_A5A5, 1'b1);
      do_req(1'b1, 1'b0, 32'h004, 32'h0, 1'b1);
      drain();
      check_eq("alias_word0", {96'b0, mem_rdata[31:0]}, 128'hA5A5_A5A5);

      // Read/write conflict behaves as a read.
      do_req(1'b0, 1'b1, 32'h08, 32'h77, 1'b1);
      do_req(1'b1, 1'b1, 32'h08, 32'h0, 1'b1);
      do_req(1'b1, 1'b0, 32'h08, 32'h0, 1'b1);
      drain();
      check_eq("conflict_word0", {96'b0, mem_rdata[31:0]}, 128'h77);

      // Requests while busy are dropped.
      d0 = done_cnt;
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
      @(negedge clk);
      mem_write = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_write = 1'b0;
      drain();
      repeat (Lat + 3) @(negedge clk);
      check_eq("busy_one_done", 128'(done_cnt - d0), 1);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
      drain();

      // Reset aborts an in-flight write.
      do_req(1'b0, 1'b1, 32'h20, 32'h11, 1'b1);
      drain();
      d0 = done_cnt;
      do_req(1'b0, 1'b1, 32'h20, 32'h55, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_rdata", mem_rdata, 0);
      check_eq("abort_ready", {127'b0, mem_ready}, 0);
      reset = 1'b0;
      repeat (Lat + 3) @(negedge clk);
      check_eq("abort_no_done", 128'(done_cnt - d0), 0);
      last_exp = '0; last_mask = '1;
      do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
      drain();
      check_eq("abort_prior_value", {96'b0, mem_rdata[31:0]}, 128'h11);

      // Random write/read pairs.
      for (int i = 0; i < 6; i++) begin
         ra = 32'($urandom_range(0, 1023));
         rv = $urandom;
         do_req(1'b0, 1'b1, ra, rv, 1'b1);
         do_req(1'b1, 1'b0, ra, 32'h0, 1'b1);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
